// File: rtl/gray_counter.sv
// gray_counter: registered binary/Gray pointer counter; GRAY_COUNTER_CHK_EN adds chk_err_o self-check
module gray_counter #(
    parameter int width    = 8,
    parameter int init_val = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [width-1:0] load_val_i,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [width-1:0] B_o,
    output logic [width-1:0] G_o,
    output logic             wrap_o
`ifdef GRAY_COUNTER_CHK_EN
    ,
    output logic             chk_err_o
`endif
);
    localparam logic [width-1:0] INIT_B = init_val[width-1:0];
    localparam logic [width-1:0] INIT_G = INIT_B ^ (INIT_B >> 1);
    localparam logic [width-1:0] ONE    = 1;
    logic [width-1:0] r_b;
    logic [width-1:0] r_g;
    logic             r_wrap;
    logic [width-1:0] w_b_next;
    logic [width-1:0] w_g_next;
    logic             w_wrap_next;
    // Next binary count and wrap flag, priority clr > load > en > hold
    always_comb begin
        w_b_next    = r_b;
        w_wrap_next = 1'b0;
        if (clr_i) w_b_next = INIT_B;
        else if (load_i) w_b_next = load_val_i;
        else if (en_i) begin
            w_b_next    = dir_i ? r_b - ONE : r_b + ONE;
            w_wrap_next = dir_i ? (r_b == '0) : (&r_b);
        end
    end
    assign w_g_next = w_b_next ^ (w_b_next >> 1);
    // Binary and Gray registers load together so Gray never comes from combinational decode of B
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_b    <= INIT_B;
            r_g    <= INIT_G;
            r_wrap <= 1'b0;
        end else begin
            r_b    <= w_b_next;
            r_g    <= w_g_next;
            r_wrap <= w_wrap_next;
        end
    end
    assign B_o    = r_b;
    assign G_o    = r_g;
    assign wrap_o = r_wrap;
`ifdef GRAY_COUNTER_CHK_EN
    logic [width-1:0] r_g_prev;
    logic             r_step;
    logic             r_chk;
    logic             w_err;
    assign w_err = (r_g != (r_b ^ (r_b >> 1))) || (r_step && ($countones(r_g ^ r_g_prev) != 1));
    // Remember previous Gray value and whether the last update was a plain count step
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_g_prev <= INIT_G;
            r_step   <= 1'b0;
            r_chk    <= 1'b0;
        end else begin
            r_g_prev <= r_g;
            r_step   <= !clr_i && !load_i && en_i;
            r_chk    <= w_err;
        end
    end
    assign chk_err_o = r_chk;
`endif
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: random and directed check of gray_counter against an arithmetic model
module tb_gray_counter;
    localparam int W = 4, INIT = 5, M = 1 << W;
    logic clk = 0, rst = 0, clr = 0, load = 0, en = 0, dir = 0;
    logic [W-1:0] lv = '0;
    logic [W-1:0] b, g, last_g, fault_val;
    logic wrap;
`ifdef GRAY_COUNTER_CHK_EN
    logic chk_err;
`endif
    int checks = 0, errors = 0;
    int m_b = INIT, m_wrap = 0;
    bit m_step = 0, cmp_on = 1;
    int gseq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    gray_counter #(.width(W), .init_val(INIT)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .load_i(load), .load_val_i(lv),
        .en_i(en), .dir_i(dir), .B_o(b), .G_o(g), .wrap_o(wrap)
`ifdef GRAY_COUNTER_CHK_EN
        , .chk_err_o(chk_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic int gray(int v);
        return v ^ (v >> 1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge with the given controls; returns 2 time units after the edge
    task automatic cyc(bit c, bit l, int v, bit e, bit d);
        clr = c; load = l; lv = v[W-1:0]; en = e; dir = d;
        @(posedge clk);
        #2;
    endtask

    // Reference model: plain modular arithmetic on an integer count
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_b = INIT; m_wrap = 0; m_step = 0;
        end else if (clr) begin
            m_b = INIT; m_wrap = 0; m_step = 0;
        end else if (load) begin
            m_b = int'(lv); m_wrap = 0; m_step = 0;
        end else if (en) begin
            m_wrap = dir ? int'(m_b == 0) : int'(m_b == M - 1);
            m_b = dir ? (m_b + M - 1) % M : (m_b + 1) % M;
            m_step = 1;
        end else begin
            m_wrap = 0; m_step = 0;
        end
    end

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_on) begin
            check("B_o", b, m_b);
            check("G_o", g, gray(m_b));
            check("wrap_o", wrap, m_wrap);
            if (m_step) check("hamming", $countones(g ^ last_g), 1);
`ifdef GRAY_COUNTER_CHK_EN
            check("chk_err_o", chk_err, 0);
`endif
        end
        last_g = g;
    end

    initial begin
        #1 rst = 1;
        #1;
        check("rst_B", b, 4'b0101);
        check("rst_G", g, 4'b0111);
        check("rst_wrap", wrap, 0);
        @(posedge clk); @(posedge clk); #2;
        rst = 0;
        cyc(0, 1, 0, 0, 0);
        check("load0_G", g, 0);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 0, 0, 1, 0);
            check("up_G", g, gseq[(i + 1) % 16]);
            check("up_wrap", wrap, int'(i == 15));
        end
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        check("down_B", b, 4'b1111);
        check("down_G", g, 4'b1000);
        check("down_wrap", wrap, 1);
        cyc(0, 0, 0, 0, 0);
        check("down_wrap_clear", wrap, 0);
        cyc(1, 1, 10, 1, 0);
        check("prio_clr_B", b, INIT);
        cyc(0, 1, 10, 1, 0);
        check("prio_load_B", b, 4'b1010);
        check("prio_load_G", g, 4'b1111);
        cyc(0, 1, 6, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, int'($urandom_range(0, 15)), 0, 1'($urandom_range(0, 1)));
            check("hold_B", b, 4'b0110);
            check("hold_G", g, 4'b0101);
            check("hold_wrap", wrap, 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        check("reverse_B", b, 4'b0101);
        cyc(0, 0, 0, 1, 0);
        #1 rst = 1;
        #1;
        check("async_rst_B", b, INIT);
        check("async_rst_G", g, 4'b0111);
        @(posedge clk); #2;
        check("rst_hold_B", b, INIT);
        rst = 0;
        cyc(0, 0, 0, 1, 0);
        check("rst_release_B", b, INIT + 1);
        for (int i = 0; i < 1000; i++)
            cyc($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                int'($urandom_range(0, M - 1)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
`ifdef GRAY_COUNTER_CHK_EN
        begin
            int pulses = 0;
            clr = 0; load = 0; en = 0;
            cmp_on = 0;
            fault_val = g ^ 4'b0011;
            force dut.w_g_next = fault_val;
            @(posedge clk); #1;
            release dut.w_g_next;
            repeat (4) begin
                @(negedge clk);
                pulses += int'(chk_err);
            end
            check("chk_pulse", pulses, 1);
            cmp_on = 1;
        end
`endif
        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
